rr_arbiter8: RTL

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_arbiter8.sv | 115 +++++++++++
 1 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a registered one-hot grant, hold-time limit
// and a one-cycle timeout pulse when the hold limit revokes a grant.
module rr_arbiter8 #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HCNT_LAST = 8'(HOLD_MAX - 1);

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] gidx, gidx_nxt;
    logic [7:0] hcnt, hcnt_nxt;
    logic [7:0] grant_nxt;
    logic       busy_nxt;
    logic       timeout_nxt;

    logic [2:0] pick;
    logic [2:0] cand;
    logic       pick_vld;
    logic       drop;
    logic       hit;
    logic       advance;
    logic       release_now;

    // Walk the offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        pick     = '0;
        cand     = '0;
        pick_vld = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            cand = ptr + 3'(i);
            if (req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    assign drop        = ~req[gidx];
    assign hit         = (hcnt == HCNT_LAST);
    assign advance     = done | drop | hit;
    assign release_now = advance | ~en;

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        gidx_nxt    = gidx;
        hcnt_nxt    = hcnt;
        grant_nxt   = grant;
        timeout_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                grant_nxt = '0;
                if (en && pick_vld) begin
                    state_nxt = GRANT;
                    gidx_nxt  = pick;
                    hcnt_nxt  = '0;
                    grant_nxt = 8'(1) << pick;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_nxt   = IDLE;
                    grant_nxt   = '0;
                    hcnt_nxt    = '0;
                    // A done or a dropped request is an orderly release, never a timeout.
                    timeout_nxt = hit & ~done & ~drop;
                    if (advance) begin
                        ptr_nxt = gidx + 3'd1;
                    end
                end else begin
                    hcnt_nxt = hcnt + 8'd1;
                end
            end
        endcase
        busy_nxt = (state_nxt == GRANT);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gidx    <= '0;
            hcnt    <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gidx    <= gidx_nxt;
            hcnt    <= hcnt_nxt;
            grant   <= grant_nxt;
            busy    <= busy_nxt;
            timeout <= timeout_nxt;
        end
    end

endmodule
